alu_commit: RTL and testbench

Sequential commit stage sitting on the output side of the ALU in the multicycle datapath. It accepts one ALU result per handshake, owns the architectural carry (C) and zero (Z) flag registers, evaluates the conditional-write code (ADD/ADC/ADZ, NDU/NDC/NDZ) against the flags held before the instruction, and either writes the result to the register file over an acknowledged write port or skips the write. It pulses completion back to the controller FSM.

---
 rtl/alu_commit.sv | 100 ++++++++++
 tb/tb_alu_commit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_commit.sv
// Commit stage behind the ALU: holds the architectural C/Z flags, evaluates the
// conditional-write code and either writes the result to the register file or skips it.
module alu_commit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_carry,
  input  logic              in_op,
  input  logic [1:0]        in_cond,
  input  logic [ADDR_W-1:0] in_dest,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  input  logic              rf_wr_ack,
  output logic              flag_c,
  output logic              flag_z,
  output logic              done,
  output logic              skipped,
  output logic              cond_err
);

  typedef enum logic [1:0] {IDLE, EVAL, WRITE, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic       carry_q;
  logic       op_q;
  logic       z_new_q;
  logic [1:0] cond_q;
  logic       wr_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The write condition looks at the flags as they stand before this instruction
  // commits; cond 11 matches none of the terms and so always suppresses the write.
  always_comb begin
    wr_ok      = (cond_q == 2'b00) | ((cond_q == 2'b01) & flag_z) | ((cond_q == 2'b10) & flag_c);
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = EVAL;
      EVAL:    state_next = wr_ok ? WRITE : DONE;
      WRITE:   if (rf_wr_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready = (state == IDLE);
  assign rf_wr_en = (state == WRITE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_addr <= '0;
      rf_wr_data <= '0;
      carry_q    <= 1'b0;
      op_q       <= 1'b0;
      cond_q     <= 2'b00;
      z_new_q    <= 1'b0;
      flag_c     <= 1'b0;
      flag_z     <= 1'b0;
      skipped    <= 1'b0;
      cond_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rf_wr_addr <= in_dest;
            rf_wr_data <= in_result;
            carry_q    <= in_carry;
            op_q       <= in_op;
            cond_q     <= in_cond;
            z_new_q    <= (in_result == '0);
          end
        end
        EVAL: begin
          skipped  <= ~wr_ok;
          cond_err <= (cond_q == 2'b11);
        end
        WRITE: begin
          // Nand-class instructions have no meaningful carry, so C is left alone.
          if (rf_wr_ack) begin
            flag_z <= z_new_q;
            if (!op_q) flag_c <= carry_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_commit.sv
// Bench for alu_commit: a transaction-level timeline model drives the stimulus and
// predicts every cycle's outputs, which a negedge process compares against the DUT.
module tb_alu_commit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic        in_carry;
  logic        in_op;
  logic [1:0]  in_cond;
  logic [2:0]  in_dest;
  logic        rf_wr_en;
  logic [2:0]  rf_wr_addr;
  logic [15:0] rf_wr_data;
  logic        rf_wr_ack;
  logic        flag_c;
  logic        flag_z;
  logic        done;
  logic        skipped;
  logic        cond_err;

  int checks = 0;
  int errors = 0;

  logic        m_c, m_z;
  logic        exp_ready, exp_wr_en, exp_done, exp_skip, exp_err;
  logic [2:0]  exp_addr;
  logic [15:0] exp_data;
  logic        last_skip, last_err;
  logic [2:0]  last_wr_addr;
  logic [15:0] last_wr_data;

  alu_commit #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry), .in_op(in_op),
    .in_cond(in_cond), .in_dest(in_dest),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_ack(rf_wr_ack),
    .flag_c(flag_c), .flag_z(flag_z),
    .done(done), .skipped(skipped), .cond_err(cond_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the timeline model
  always @(negedge clk) begin
    checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    checkOutput("rf_wr_en", 32'(rf_wr_en), 32'(exp_wr_en));
    checkOutput("done", 32'(done), 32'(exp_done));
    checkOutput("flag_c", 32'(flag_c), 32'(m_c));
    checkOutput("flag_z", 32'(flag_z), 32'(m_z));
    checkOutput("rf_wr_addr", 32'(rf_wr_addr), 32'(exp_addr));
    checkOutput("rf_wr_data", 32'(rf_wr_data), 32'(exp_data));
    if (exp_done) begin
      checkOutput("skipped", 32'(skipped), 32'(exp_skip));
      checkOutput("cond_err", 32'(cond_err), 32'(exp_err));
    end
  end

  task automatic junk();
    in_valid  = 1'($urandom_range(0, 1));
    in_result = 16'($urandom);
    in_carry  = 1'($urandom_range(0, 1));
    in_op     = 1'($urandom_range(0, 1));
    in_cond   = 2'($urandom_range(0, 3));
    in_dest   = 3'($urandom_range(0, 7));
    rf_wr_ack = 1'($urandom_range(0, 1));
  endtask

  // Called one step after a clock edge with the DUT idle; runs one whole instruction.
  task automatic applyStimulus(input logic [15:0] res, input logic cry, input logic op,
                               input logic [1:0] cond, input logic [2:0] dest,
                               input int ack_delay, input bit abort);
    logic wr;
    in_valid  = 1'b1;
    in_result = res;
    in_carry  = cry;
    in_op     = op;
    in_cond   = cond;
    in_dest   = dest;
    rf_wr_ack = 1'($urandom_range(0, 1));
    wr = (cond == 2'b00) || (cond == 2'b01 && m_z) || (cond == 2'b10 && m_c);
    @(posedge clk); #1;
    exp_ready = 1'b0;
    exp_addr  = dest;
    exp_data  = res;
    junk();
    @(posedge clk); #1;
    if (wr) begin
      for (int j = 0; j <= ack_delay; j++) begin
        exp_wr_en = 1'b1;
        junk();
        rf_wr_ack = (j == ack_delay);
        last_wr_addr = rf_wr_addr;
        last_wr_data = rf_wr_data;
        if (abort) begin
          rf_wr_ack = 1'b0;
          in_valid  = 1'b0;
          #2 reset = 1'b1;
          #1;
          checkOutput("abort_wr_en", 32'(rf_wr_en), 32'd0);
          checkOutput("abort_ready", 32'(in_ready), 32'd1);
          checkOutput("abort_flag_c", 32'(flag_c), 32'd0);
          checkOutput("abort_flag_z", 32'(flag_z), 32'd0);
          checkOutput("abort_done", 32'(done), 32'd0);
          m_c = 1'b0; m_z = 1'b0;
          exp_wr_en = 1'b0; exp_ready = 1'b1;
          exp_addr = '0; exp_data = '0;
          @(posedge clk); #1;
          reset = 1'b0;
          return;
        end
        @(posedge clk); #1;
      end
      m_z = (res == 16'h0000);
      if (!op) m_c = cry;
      exp_wr_en = 1'b0;
      exp_skip  = 1'b0;
      exp_err   = 1'b0;
    end else begin
      exp_skip = 1'b1;
      exp_err  = (cond == 2'b11);
    end
    exp_done  = 1'b1;
    last_skip = skipped;
    last_err  = cond_err;
    junk();
    @(posedge clk); #1;
    exp_done  = 1'b0;
    exp_ready = 1'b1;
    in_valid  = 1'b0;
    rf_wr_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_result = '0; in_carry = 1'b0; in_op = 1'b0;
    in_cond = 2'b00; in_dest = '0; rf_wr_ack = 1'b0;
    m_c = 1'b0; m_z = 1'b0;
    exp_ready = 1'b1; exp_wr_en = 1'b0; exp_done = 1'b0;
    exp_skip = 1'b0; exp_err = 1'b0; exp_addr = '0; exp_data = '0;
    last_skip = 1'b0; last_err = 1'b0; last_wr_addr = '0; last_wr_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    applyStimulus(16'h1234, 1'b0, 1'b0, 2'b00, 3'd3, 0, 1'b0);
    checkOutput("t1_addr", 32'(last_wr_addr), 32'd3);
    checkOutput("t1_data", 32'(last_wr_data), 32'h1234);
    checkOutput("t1_skip", 32'(last_skip), 32'd0);
    checkOutput("t1_c", 32'(flag_c), 32'd0);
    checkOutput("t1_z", 32'(flag_z), 32'd0);

    applyStimulus(16'h0000, 1'b1, 1'b0, 2'b00, 3'd1, 0, 1'b0);
    checkOutput("t2_c", 32'(flag_c), 32'd1);
    checkOutput("t2_z", 32'(flag_z), 32'd1);
    applyStimulus(16'h0005, 1'b0, 1'b0, 2'b10, 3'd2, 1, 1'b0);
    checkOutput("t2_adc_skip", 32'(last_skip), 32'd0);
    checkOutput("t2_adc_data", 32'(last_wr_data), 32'h0005);
    checkOutput("t2_adc_c", 32'(flag_c), 32'd0);
    checkOutput("t2_adc_z", 32'(flag_z), 32'd0);
    applyStimulus(16'h0000, 1'b0, 1'b1, 2'b01, 3'd4, 0, 1'b0);
    checkOutput("t2_ndz_skip", 32'(last_skip), 32'd1);
    checkOutput("t2_ndz_z", 32'(flag_z), 32'd0);

    applyStimulus(16'hFFFF, 1'b1, 1'b0, 2'b00, 3'd5, 0, 1'b0);
    applyStimulus(16'h0000, 1'b0, 1'b1, 2'b00, 3'd6, 0, 1'b0);
    checkOutput("t3_ndu_c", 32'(flag_c), 32'd1);
    checkOutput("t3_ndu_z", 32'(flag_z), 32'd1);

    applyStimulus(16'h7777, 1'b0, 1'b0, 2'b11, 3'd7, 0, 1'b0);
    checkOutput("t4_err", 32'(last_err), 32'd1);
    checkOutput("t4_skip", 32'(last_skip), 32'd1);
    checkOutput("t4_c", 32'(flag_c), 32'd1);
    checkOutput("t4_z", 32'(flag_z), 32'd1);

    applyStimulus(16'hABCD, 1'b0, 1'b0, 2'b00, 3'd2, 5, 1'b0);
    checkOutput("t5_data", 32'(last_wr_data), 32'hABCD);
    checkOutput("t5_c", 32'(flag_c), 32'd0);
    checkOutput("t5_z", 32'(flag_z), 32'd0);

    applyStimulus(16'h0000, 1'b1, 1'b0, 2'b00, 3'd1, 0, 1'b0);
    applyStimulus(16'h4242, 1'b0, 1'b0, 2'b00, 3'd3, 3, 1'b1);

    for (int n = 0; n < 200; n++) begin
      logic [15:0] r;
      r = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      applyStimulus(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                    int'($urandom_range(0, 4)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
